multiplier_arbiter: RTL and testbench

- Shares one sequential shift-add multiplier between REQUESTERS independent clients.
- Round-robin arbitration picks a client, latches its operands, fires a one-cycle start to the multiplier, and waits for completion.
- Returns the product with a one-hot valid pulse to the winning client.
- Sits between client logic (e.g. keypad/switch front-ends) and the shared multiplier; the product feeds the seven-segment display path.

---
 rtl/multiplier_arbiter.sv | 170 +++++++++++++++++
 tb/tb_multiplier_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_arbiter.sv
// Round-robin front end that shares one sequential multiplier between REQUESTERS
// clients; one transaction in flight, aborted with an error pulse after TIMEOUT cycles.
module multiplier_arbiter #(
   parameter int REQUESTERS = 4,
   parameter int WIDTH      = 4,
   parameter int TIMEOUT    = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [REQUESTERS-1:0]         request,
   input  logic [REQUESTERS*WIDTH-1:0]   operand_one,
   input  logic [REQUESTERS*WIDTH-1:0]   operand_two,
   output logic [REQUESTERS-1:0]         grant,
   output logic [REQUESTERS-1:0]         valid,
   output logic [2*WIDTH-1:0]            product,
   output logic                          error,
   output logic                          mul_start,
   output logic [WIDTH-1:0]              mul_one,
   output logic [WIDTH-1:0]              mul_two,
   input  logic                          mul_done,
   input  logic [2*WIDTH-1:0]            mul_product
);

   localparam int PTR_W   = $clog2(REQUESTERS);
   localparam int TIMER_W = $clog2(TIMEOUT) + 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
   localparam logic [PTR_W-1:0]   PTR_RESET  = PTR_W'(REQUESTERS - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LAUNCH  = 2'd1,
      ST_WAIT    = 2'd2,
      ST_DELIVER = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [REQUESTERS-1:0]   grant_q, grant_d;
   logic [REQUESTERS-1:0]   valid_q, valid_d;
   logic [2*WIDTH-1:0]      product_q, product_d;
   logic                    error_q, error_d;
   logic                    start_q, start_d;
   logic [WIDTH-1:0]        one_q, one_d;
   logic [WIDTH-1:0]        two_q, two_d;
   logic [TIMER_W-1:0]      timer_q, timer_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [PTR_W-1:0]        winner_q, winner_d;

   logic                    found_s;
   logic [PTR_W-1:0]        win_idx_s;
   logic [PTR_W-1:0]        cand_s;
   logic [WIDTH-1:0]        op_one_a [REQUESTERS];
   logic [WIDTH-1:0]        op_two_a [REQUESTERS];

   for (genvar g = 0; g < REQUESTERS; g++) begin : g_slice
      assign op_one_a[g] = operand_one[g*WIDTH +: WIDTH];
      assign op_two_a[g] = operand_two[g*WIDTH +: WIDTH];
   end

   // Rotating search: first requester above the pointer, wrapping around.
   always_comb begin
      found_s   = 1'b0;
      win_idx_s = '0;
      cand_s    = '0;
      for (int k = 1; k <= REQUESTERS; k++) begin
         cand_s = PTR_W'((int'(ptr_q) + k) % REQUESTERS);
         if (!found_s && request[cand_s]) begin
            found_s   = 1'b1;
            win_idx_s = cand_s;
         end else begin
            found_s   = found_s;
         end
      end
   end

   // Transaction sequencing; every output is produced as a registered next value.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      valid_d   = '0;
      product_d = product_q;
      error_d   = 1'b0;
      start_d   = 1'b0;
      one_d     = one_q;
      two_d     = two_q;
      timer_d   = timer_q;
      ptr_d     = ptr_q;
      winner_d  = winner_q;
      case (state_q)
         ST_IDLE: begin
            if (found_s) begin
               grant_d  = REQUESTERS'(1) << win_idx_s;
               winner_d = win_idx_s;
               one_d    = op_one_a[win_idx_s];
               two_d    = op_two_a[win_idx_s];
               start_d  = 1'b1;
               state_d  = ST_LAUNCH;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion in the final timer cycle still counts as success.
            if (mul_done) begin
               product_d = mul_product;
               valid_d   = grant_q;
               state_d   = ST_DELIVER;
            end else if (timer_q == TIMER_LAST) begin
               error_d = 1'b1;
               grant_d = '0;
               ptr_d   = winner_q;
               timer_d = '0;
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         ST_DELIVER: begin
            grant_d = '0;
            ptr_d   = winner_q;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         valid_q   <= '0;
         product_q <= '0;
         error_q   <= 1'b0;
         start_q   <= 1'b0;
         one_q     <= '0;
         two_q     <= '0;
         timer_q   <= '0;
         ptr_q     <= PTR_RESET;
         winner_q  <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         product_q <= product_d;
         error_q   <= error_d;
         start_q   <= start_d;
         one_q     <= one_d;
         two_q     <= two_d;
         timer_q   <= timer_d;
         ptr_q     <= ptr_d;
         winner_q  <= winner_d;
      end
   end

   assign grant     = grant_q;
   assign valid     = valid_q;
   assign product   = product_q;
   assign error     = error_q;
   assign mul_start = start_q;
   assign mul_one   = one_q;
   assign mul_two   = two_q;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter with a delayed-done multiplier model and
// a scoreboard of expected (valid, product) pairs popped whenever valid pulses.
module tb_multiplier_arbiter;
   localparam int N     = 4;
   localparam int W     = 4;
   localparam int TO    = 32;
   localparam int DELAY = 9;

   typedef struct packed {
      logic [N-1:0]   v;
      logic [2*W-1:0] p;
   } exp_t;

   logic           clock = 1'b0;
   logic           reset;
   logic [N-1:0]   request;
   logic [N*W-1:0] operand_one, operand_two;
   logic [N-1:0]   grant, valid;
   logic [2*W-1:0] product;
   logic           error, mul_start, mul_done;
   logic [W-1:0]   mul_one, mul_two;
   logic [2*W-1:0] mul_product;

   logic [W-1:0]   op1 [N];
   logic [W-1:0]   op2 [N];
   logic           never_done, force_done, force_sel;
   logic [2*W-1:0] force_prod;
   int             model_cnt;
   logic [2*W-1:0] model_res;

   exp_t           sb [$];
   exp_t           mon_e;
   int             tests = 0, fails = 0;
   int             start_cnt = 0, valid_cnt = 0, err_cnt = 0;

   multiplier_arbiter #(.REQUESTERS(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .request(request),
      .operand_one(operand_one), .operand_two(operand_two),
      .grant(grant), .valid(valid), .product(product), .error(error),
      .mul_start(mul_start), .mul_one(mul_one), .mul_two(mul_two),
      .mul_done(mul_done), .mul_product(mul_product)
   );

   always #5 clock = ~clock;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         operand_one[i*W +: W] = op1[i];
         operand_two[i*W +: W] = op2[i];
      end
   end

   // Multiplier model: done DELAY cycles after the start pulse, cleared by reset.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         model_cnt <= 0;
         model_res <= '0;
      end else if (mul_start) begin
         model_cnt <= DELAY;
         model_res <= {4'd0, mul_one} * {4'd0, mul_two};
      end else if (model_cnt != 0) begin
         model_cnt <= model_cnt - 1;
      end
   end

   assign mul_done    = (!never_done && model_cnt == 1) || force_done;
   assign mul_product = force_sel ? force_prod : model_res;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bound_fail(input string tag);
      tests++;
      fails++;
      $error("FAIL %s: bound expired, event not observed", tag);
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      do begin tick(); n++; end while (grant === 4'b0000 && n < 100);
      if (grant === 4'b0000) bound_fail("wait_grant");
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin tick(); n++; end while (valid === 4'b0000 && n < 200);
      if (valid === 4'b0000) bound_fail("wait_valid");
   endtask

   task automatic wait_error(output int n);
      n = 0;
      do begin tick(); n++; end while (error !== 1'b1 && n < 200);
      if (error !== 1'b1) bound_fail("wait_error");
   endtask

   // Monitor: event counters, per-cycle invariants and scoreboard pops on valid.
   always @(negedge clock) begin
      if (mul_start === 1'b1) start_cnt++;
      if (error === 1'b1) err_cnt++;
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
      check("valid_in_grant", 32'(valid & ~grant), 32'd0);
      if (valid !== 4'b0000) begin
         valid_cnt++;
         if (sb.size() == 0) begin
            bound_fail("sb_underflow");
         end else begin
            mon_e = sb.pop_front();
            check("sb_valid", 32'(valid), 32'(mon_e.v));
            check("sb_product", 32'(product), 32'(mon_e.p));
         end
      end
   end

   initial begin
      int n, base, pre_v, pre_e;
      logic [N-1:0] eg;
      reset = 1'b1; request = '0; never_done = 1'b0; force_done = 1'b0;
      force_sel = 1'b0; force_prod = '0;
      for (int i = 0; i < N; i++) begin op1[i] = '0; op2[i] = '0; end
      tick(); tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_start", 32'(mul_start), 32'd0);
      check("rst_one", 32'(mul_one), 32'd0);
      check("rst_two", 32'(mul_two), 32'd0);
      reset = 1'b0;
      tick();

      // 1: single client 2, 3*5
      op1[2] = 4'd3; op2[2] = 4'd5; request = 4'b0100;
      sb.push_back('{4'b0100, 8'd15});
      base = start_cnt;
      wait_grant(n);
      check("t1_grant_lat", 32'(n), 32'd1);
      check("t1_grant", 32'(grant), 32'b0100);
      check("t1_start", 32'(mul_start), 32'd1);
      check("t1_one", 32'(mul_one), 32'd3);
      check("t1_two", 32'(mul_two), 32'd5);
      request = '0;
      wait_valid(n);
      check("t1_valid_lat", 32'(n), 32'd10);
      tick();
      check("t1_valid_pulse", 32'(valid), 32'd0);
      check("t1_grant_clr", 32'(grant), 32'd0);
      check("t1_product", 32'(product), 32'd15);
      #1 check("t1_starts", 32'(start_cnt - base), 32'd1);

      // 2: all requesting, round robin from a fresh pointer
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < N; i++) begin op1[i] = W'(i + 1); op2[i] = W'(i + 2); end
      request = 4'b1111;
      for (int t = 0; t < 5; t++) sb.push_back('{4'b0001 << (t % N), 8'((t % N + 1) * (t % N + 2))});
      base = start_cnt;
      for (int t = 0; t < 5; t++) begin
         eg = 4'b0001 << (t % N);
         wait_grant(n);
         check("t2_gap", 32'(n), 32'd1);
         check("t2_grant", 32'(grant), 32'(eg));
         wait_valid(n);
         if (t == 4) request = '0;
         tick();
         check("t2_idle", 32'(grant), 32'd0);
      end
      #1 check("t2_starts", 32'(start_cnt - base), 32'd5);

      // 3: timeout on client 0, client 1 pending
      never_done = 1'b1; request = 4'b0001;
      pre_v = valid_cnt; pre_e = err_cnt;
      wait_grant(n);
      check("t3_grant", 32'(grant), 32'b0001);
      request = 4'b0010;
      tick();
      wait_error(n);
      check("t3_err_lat", 32'(n), 32'(TO));
      check("t3_grant_clr", 32'(grant), 32'd0);
      check("t3_product", 32'(product), 32'd2);
      #1 check("t3_no_valid", 32'(valid_cnt - pre_v), 32'd0);
      check("t3_err_cnt", 32'(err_cnt - pre_e), 32'd1);
      never_done = 1'b0;
      sb.push_back('{4'b0010, 8'd6});
      wait_grant(n);
      check("t3_next_grant", 32'(grant), 32'b0010);
      check("t3_err_pulse", 32'(error), 32'd0);
      request = '0;
      wait_valid(n);

      // 4: request and operands dropped during WAIT
      op1[3] = 4'd15; op2[3] = 4'd15; request = 4'b1000;
      sb.push_back('{4'b1000, 8'd225});
      wait_grant(n);
      check("t4_grant", 32'(grant), 32'b1000);
      tick(); tick();
      request = '0; op1[3] = '0; op2[3] = '0;
      tick();
      check("t4_one_held", 32'(mul_one), 32'd15);
      check("t4_two_held", 32'(mul_two), 32'd15);
      wait_valid(n);
      check("t4_valid", 32'(valid), 32'b1000);

      // 5: reset in WAIT, then client 0 first
      request = 4'b0010;
      wait_grant(n);
      request = '0;
      tick(); tick();
      check("t5_grant", 32'(grant), 32'b0010);
      pre_e = err_cnt;
      reset = 1'b1;
      #1;
      check("t5_grant0", 32'(grant), 32'd0);
      check("t5_valid0", 32'(valid), 32'd0);
      check("t5_product0", 32'(product), 32'd0);
      check("t5_error0", 32'(error), 32'd0);
      check("t5_start0", 32'(mul_start), 32'd0);
      check("t5_one0", 32'(mul_one), 32'd0);
      check("t5_two0", 32'(mul_two), 32'd0);
      tick();
      op1[0] = 4'd7; op2[0] = 4'd9;
      reset = 1'b0; request = 4'b0011;
      sb.push_back('{4'b0001, 8'd63});
      wait_grant(n);
      check("t5_first", 32'(grant), 32'b0001);
      request = '0;
      wait_valid(n);
      #1 check("t5_no_err", 32'(err_cnt - pre_e), 32'd0);

      // 6: done in IDLE ignored; done on the last timer cycle wins
      tick();
      force_sel = 1'b1; force_prod = 8'hA5; force_done = 1'b1;
      tick();
      force_done = 1'b0; force_sel = 1'b0;
      check("t6_idle_valid", 32'(valid), 32'd0);
      check("t6_idle_product", 32'(product), 32'd63);
      check("t6_idle_grant", 32'(grant), 32'd0);
      tick();
      check("t6_idle_start", 32'(mul_start), 32'd0);
      never_done = 1'b1; request = 4'b0100;
      sb.push_back('{4'b0100, 8'd12});
      pre_e = err_cnt;
      wait_grant(n);
      check("t6_grant", 32'(grant), 32'b0100);
      request = '0;
      tick();
      repeat (TO - 1) tick();
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      check("t6_valid", 32'(valid), 32'b0100);
      check("t6_no_error", 32'(error), 32'd0);
      tick();
      check("t6_no_error2", 32'(error), 32'd0);
      #1 check("t6_err_cnt", 32'(err_cnt - pre_e), 32'd0);
      never_done = 1'b0;

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
